// File: rtl/comb_differentiator_if.sv
// Stream bundle for comb_differentiator: control, input sample channel and result channel.
//
// Handshake: a transfer happens on a rising edge where i_CLK_EN, the channel's
// valid and the channel's ready are all high. The producer holds valid and data
// steady until that transfer. o_READY is combinational from registered state
// and inputs and does not depend on i_VALID.
interface comb_differentiator_if #(
  parameter int W = 8
);
  logic         i_CLK_EN;
  logic         i_CLEAR;
  logic         i_VALID;
  logic         o_READY;
  logic [W-1:0] i_SAMPLE;
  logic         o_VALID;
  logic         i_READY;
  logic [W-1:0] o_DIFFERENCE;
  logic         o_OVERFLOW;
  logic         o_PRIMED;

  // Drives the block: enable, clear, upstream samples and downstream ready.
  modport master (
    output i_CLK_EN, i_CLEAR, i_VALID, i_SAMPLE, i_READY,
    input  o_READY, o_VALID, o_DIFFERENCE, o_OVERFLOW, o_PRIMED
  );

  // The differentiator itself.
  modport slave (
    input  i_CLK_EN, i_CLEAR, i_VALID, i_SAMPLE, i_READY,
    output o_READY, o_VALID, o_DIFFERENCE, o_OVERFLOW, o_PRIMED
  );
endinterface

// File: rtl/comb_differentiator.sv
// Streaming signed differencer y[n] = x[n] - x[n-M] over accepted samples.
// One output register with valid/ready on both sides. It takes a new sample in
// the same cycle the held result is consumed, so it runs at full rate with no bubble.
// The history is zero before priming, so the first results equal the raw inputs.
module comb_differentiator #(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_DELAY      = 1,
  parameter int p_SATURATE   = 0
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_N,
  comb_differentiator_if.slave  bus
);
  localparam int W  = p_DATA_WIDTH;
  localparam int M  = p_DELAY;
  localparam int CW = $clog2(M + 1);

  logic [W-1:0]  hist_q [M];
  logic [W-1:0]  hist_d [M];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  diff_q, diff_d;

  logic [W:0]    d_full;
  logic          ovf_now;
  logic [W-1:0]  res_now;
  logic          ready;
  logic          accept;
  logic          consume;

  // The block can take a sample when the output slot is free or is being drained now.
  assign ready   = bus.i_CLK_EN && (!valid_q || bus.i_READY);
  assign accept  = bus.i_CLK_EN && bus.i_VALID && ready;
  assign consume = bus.i_CLK_EN && valid_q && bus.i_READY;

  assign bus.o_READY      = ready;
  assign bus.o_VALID      = valid_q;
  assign bus.o_DIFFERENCE = diff_q;
  assign bus.o_OVERFLOW   = ovf_q;
  assign bus.o_PRIMED     = (cnt_q == CW'(M));

  // Difference at W+1 bits, overflow from the top two bits, optional clamp.
  always_comb begin
    d_full  = {bus.i_SAMPLE[W-1], bus.i_SAMPLE} - {hist_q[M-1][W-1], hist_q[M-1]};
    ovf_now = d_full[W] ^ d_full[W-1];
    res_now = d_full[W-1:0];
    if (p_SATURATE != 0 && ovf_now) begin
      res_now = d_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Next state: clear beats accept and consume; accept refills the slot even while draining.
  always_comb begin
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    diff_d  = diff_q;
    if (bus.i_CLK_EN) begin
      if (bus.i_CLEAR) begin
        for (int i = 0; i < M; i++) hist_d[i] = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        diff_d  = '0;
      end else if (accept) begin
        for (int i = M - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
        hist_d[0] = bus.i_SAMPLE;
        diff_d    = res_now;
        ovf_d     = ovf_now;
        valid_d   = 1'b1;
        if (cnt_q != CW'(M)) cnt_d = cnt_q + CW'(1);
      end else if (consume) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      for (int i = 0; i < M; i++) hist_q[i] <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      diff_q  <= '0;
    end else begin
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      diff_q  <= diff_d;
    end
  end
endmodule

// File: doc/comb_differentiator.md
# comb_differentiator

Streaming signed differencer computing y[n] = x[n] − x[n−M] over accepted samples, with a valid/ready handshake on both sides. It is the inverse of the accumulator. Fed a wrapped running sum, it recovers the original summands exactly. It serves as the comb stage of CIC decimators and as the checker-side reconstruction of accumulated streams.

## Interface
- p_DATA_WIDTH, 8, sample and result width W (≥2).
- p_DELAY, 1, differential delay M (1..8).
- p_SATURATE, 0, 0 = modular (wrap) result, 1 = clamp to signed W-bit range.

- i_CLK  input  1  rising-edge clock, sole clock domain.
- i_RESET_N  input  1  asynchronous, active-low reset.
- i_CLK_EN  input  1  global enable; when low the block is frozen.
- i_CLEAR  input  1  synchronous flush of history and output stage.
- i_VALID  input  1  upstream sample valid.
- o_READY  output  1  block accepts i_SAMPLE this cycle.
- i_SAMPLE  input  W  signed input sample.
- o_VALID  output  1  o_DIFFERENCE holds an unconsumed result.
- i_READY  input  1  downstream accepts result.
- o_DIFFERENCE  output  W  signed result.
- o_OVERFLOW  output  1  the true difference of this result did not fit in W bits. Qualified by o_VALID.
- o_PRIMED  output  1  M samples accepted since reset or clear, so the history is real data.

## Operation
- Accept when i_CLK_EN && i_VALID && o_READY. Consume when i_CLK_EN && o_VALID && i_READY.
- o_READY = i_CLK_EN && (!o_VALID || i_READY). This is combinational from registered state and inputs.
- History is an M-deep shift register of previously accepted samples, initialised to 0. Before priming, missing history reads as 0, so the first output equals x[0].
- Difference is computed at W+1 bits: d = sext(x) − sext(hist[M−1]).
  - o_OVERFLOW = (d[W] != d[W−1]).
  - p_SATURATE=0: o_DIFFERENCE = d[W−1:0], i.e. mod 2^W.
  - p_SATURATE=1: on overflow, clamp to +(2^(W−1)−1) or −2^(W−1) by the sign of d. Otherwise d[W−1:0].
- On accept:
  - Shift x into the history.
  - Load the output register with the result and the overflow flag.
  - Set o_VALID.
  - Increment the priming counter, saturating at M. o_PRIMED = (count == M).
- On consume without accept: clear o_VALID. Data may hold its last value.
- Accept and consume in the same cycle: the new result replaces the old one, o_VALID stays 1, and there is no bubble.
- i_CLK_EN low: no state changes, and i_VALID and i_READY are ignored.
- i_CLEAR (when i_CLK_EN high):
  - History, counter, o_VALID, o_OVERFLOW and o_DIFFERENCE go to 0.
  - Clear wins over a simultaneous accept; the sample is dropped, since o_READY is still high that cycle and upstream sees a transfer.
  - Clear wins over a simultaneous consume.
- States are implied by o_VALID and the priming counter: EMPTY, HOLDING (o_VALID=1, waiting on i_READY), and PRIMING versus PRIMED.

## Timing
- Asynchronous reset (i_RESET_N=0): o_VALID=0, o_DIFFERENCE=0, o_OVERFLOW=0, o_PRIMED=0, history=0, counter=0. o_READY = i_CLK_EN while in reset. Release is synchronised externally.
- Latency: a sample accepted at edge k appears on o_DIFFERENCE/o_VALID after edge k, one cycle.
- Throughput: one sample per cycle while i_READY=1 and i_CLK_EN=1.
- Backpressure: while o_VALID && !i_READY, o_DIFFERENCE and o_OVERFLOW are stable and o_READY=0.
- o_PRIMED rises on the edge of the M-th accept.

## Test plan
- Reset mid-stream with o_VALID=1 and i_READY=0:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first accepted 7 produces o_DIFFERENCE=7.
- M=1, W=8, wrap mode, inputs 10, 30, 25 with i_READY=1:
  - Outputs 10, 20, −5 on consecutive cycles, o_OVERFLOW=0.
  - o_PRIMED=1 after the first accept.
- M=1, W=8, inputs 120 then −126 (a wrapped accumulator of +10):
  - Wrap mode: o_DIFFERENCE=10, o_OVERFLOW=1.
  - p_SATURATE=1: o_DIFFERENCE=−128, o_OVERFLOW=1.
- M=4, inputs 1..8 back-to-back:
  - Outputs 1, 2, 3, 4, 4, 4, 4, 4.
  - o_PRIMED rises after the 4th accept.
- Backpressure and enable:
  - Result 20 is valid and i_READY is held low for 3 cycles → o_DIFFERENCE stays 20, o_READY=0, the pending input 25 is not accepted.
  - i_READY rises → 20 is consumed, 25 is accepted in the same cycle, and −5 appears next.
  - i_CLK_EN=0 for 2 cycles during a transfer → no change.
- i_CLEAR asserted together with an accept of 50 after history 30:
  - All outputs are 0 and o_PRIMED=0.
  - The next accept of 5 yields 5, not −25.
